// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT datapath: sample width, frame size
// and the bit-reversal map used by both the input buffer and the fft8 stage.
package fft_pkg;

  localparam int DATA_W = 16;
  localparam int N      = 8;
  localparam int LOG2N  = 3;

  // Reverse the three index bits: 0->0, 1->4, 2->2, 3->6, 4->1, 5->5, 6->3, 7->7.
  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] k);
    return {k[0], k[1], k[2]};
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame bank: N complex entries, single write port, whole bank visible
// in parallel. Contents are not reset; the owner tracks validity separately.
module fft_frame_bank #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int N      = fft_pkg::N,
  parameter int AW     = fft_pkg::LOG2N
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wre_i,
  input  logic [DATA_W-1:0] wim_i,
  output logic [N*DATA_W-1:0] rd_re_o,
  output logic [N*DATA_W-1:0] rd_im_o
);

  logic [N*DATA_W-1:0] re_q;
  logic [N*DATA_W-1:0] im_q;

  // Store one complex sample into the addressed slot
  always_ff @(posedge clk) begin
    if (we_i) begin
      re_q[waddr_i*DATA_W +: DATA_W] <= wre_i;
      im_q[waddr_i*DATA_W +: DATA_W] <= wim_i;
    end
  end

  assign rd_re_o = re_q;
  assign rd_im_o = im_q;

endmodule

// File: rtl/fft8_input_buffer.sv
// Ping-pong serial-to-parallel buffer feeding the fft8 stage. Samples arrive
// in natural order and are written straight into bit-reversed slots, so a
// completed bank is already in the order the butterfly network expects.
module fft8_input_buffer #(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int N      = fft_pkg::N
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_re,
  input  logic [DATA_W-1:0]   in_im,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*DATA_W-1:0] out_re,
  output logic [N*DATA_W-1:0] out_im,
  output logic                frame_err
);

  import fft_pkg::*;

  if (N != 8) begin : g_n_check
    $error("fft8_input_buffer: only N=8 is supported");
  end

  logic                rst_meta_q;
  logic                rst_sync_q;
  logic                ready_en_q;
  logic [LOG2N-1:0]    wr_idx_q, wr_idx_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          full_q, full_d;
  logic                frame_err_q, frame_err_d;

  logic                accept;
  logic                consume;
  logic                idx_last;
  logic [LOG2N-1:0]    waddr;
  logic [N*DATA_W-1:0] bank0_re, bank0_im, bank1_re, bank1_im;

  // Reset synchroniser: assert immediately, release two clk edges later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end

  // Upstream handshake enable; kept off the reset net so the synchronised
  // reset only ever drives flop reset pins
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) ready_en_q <= 1'b0;
    else             ready_en_q <= 1'b1;
  end

  assign in_ready  = ready_en_q & ~full_q[wr_ptr_q];
  assign out_valid = full_q[rd_ptr_q];
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;
  assign idx_last  = (wr_idx_q == LOG2N'(N-1));
  assign waddr     = bitrev3(wr_idx_q);
  assign frame_err = frame_err_q;

  // Next-state for write index, bank pointers, full flags and framing error.
  // A fill and a drain in the same cycle always target different banks.
  always_comb begin
    wr_idx_d    = wr_idx_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    full_d      = full_q;
    frame_err_d = 1'b0;
    if (accept) begin
      if (idx_last) begin
        full_d[wr_ptr_q] = 1'b1;
        wr_idx_d         = '0;
        wr_ptr_d         = ~wr_ptr_q;
        frame_err_d      = ~in_last;
      end else if (in_last) begin
        wr_idx_d    = '0;
        frame_err_d = 1'b1;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end
    if (consume) begin
      full_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ~rd_ptr_q;
    end
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      wr_idx_q    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      full_q      <= 2'b00;
      frame_err_q <= 1'b0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      full_q      <= full_d;
      frame_err_q <= frame_err_d;
    end
  end

  fft_frame_bank #(.DATA_W(DATA_W), .N(N), .AW(LOG2N)) u_bank0 (
    .clk     (clk),
    .we_i    (accept & ~wr_ptr_q),
    .waddr_i (waddr),
    .wre_i   (in_re),
    .wim_i   (in_im),
    .rd_re_o (bank0_re),
    .rd_im_o (bank0_im)
  );

  fft_frame_bank #(.DATA_W(DATA_W), .N(N), .AW(LOG2N)) u_bank1 (
    .clk     (clk),
    .we_i    (accept & wr_ptr_q),
    .waddr_i (waddr),
    .wre_i   (in_re),
    .wim_i   (in_im),
    .rd_re_o (bank1_re),
    .rd_im_o (bank1_im)
  );

  assign out_re = rd_ptr_q ? bank1_re : bank0_re;
  assign out_im = rd_ptr_q ? bank1_im : bank0_im;

endmodule

// File: tb/tb_fft8_input_buffer.sv
// Self-checking bench for fft8_input_buffer: a table of directed vectors,
// hand-written multi-cycle sequences and a randomized run, all checked
// against a frame-queue reference model.
module tb_fft8_input_buffer;

  localparam int DW = 16;
  localparam int NN = 8;
  localparam int FW = NN * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_re = '0;
  logic [DW-1:0] in_im = '0;
  logic          in_ready;
  logic          out_valid;
  logic          frame_err;
  logic [FW-1:0] out_re;
  logic [FW-1:0] out_im;

  always #5 clk = ~clk;

  fft8_input_buffer #(.DATA_W(DW), .N(NN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .frame_err (frame_err)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkf(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [FW-1:0] re;
    logic [FW-1:0] im;
  } frame_t;

  frame_t        mq[$];
  logic [DW-1:0] cur_re[NN];
  logic [DW-1:0] cur_im[NN];
  int            mcnt = 0;
  logic          exp_err = 1'b0;
  int            n_dut_out = 0;
  int            n_stall = 0;

  function automatic int brev(input int k);
    return ((k % 2) * 4) + (((k / 2) % 2) * 2) + (k / 4);
  endfunction

  task automatic model_reset();
    mq.delete();
    mcnt    = 0;
    exp_err = 1'b0;
  endtask

  // One clock: check DUT against the model, drive new inputs, advance model.
  task automatic step(input logic v, input logic [DW-1:0] re, input logic [DW-1:0] im,
                      input logic last, input logic ordy);
    frame_t f;
    logic   acc, cons;
    @(negedge clk);
    chk1("in_ready", in_ready, mq.size() < 2);
    chk1("out_valid", out_valid, mq.size() > 0);
    chk1("frame_err", frame_err, exp_err);
    if (mq.size() > 0) begin
      chkf("out_re", out_re, mq[0].re);
      chkf("out_im", out_im, mq[0].im);
    end
    in_valid  = v;
    in_re     = re;
    in_im     = im;
    in_last   = last;
    out_ready = ordy;
    if (out_valid && ordy) n_dut_out++;
    if (v && !in_ready) n_stall++;
    acc     = v && (mq.size() < 2);
    cons    = ordy && (mq.size() > 0);
    exp_err = 1'b0;
    if (cons) void'(mq.pop_front());
    if (acc) begin
      cur_re[mcnt] = re;
      cur_im[mcnt] = im;
      if (mcnt == NN - 1) begin
        for (int j = 0; j < NN; j++) begin
          f.re[j*DW +: DW] = cur_re[brev(j)];
          f.im[j*DW +: DW] = cur_im[brev(j)];
        end
        mq.push_back(f);
        exp_err = !last;
        mcnt    = 0;
      end else if (last) begin
        exp_err = 1'b1;
        mcnt    = 0;
      end else begin
        mcnt++;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, '0, 1'b0, ordy);
  endtask

  task automatic send_frame(input logic ordy);
    for (int k = 0; k < NN; k++)
      step(1'b1, DW'($urandom), DW'($urandom), k == NN - 1, ordy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #1;
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_frame_err", frame_err, 1'b0);
    repeat (2) @(negedge clk);
    chk1("rst_hold_in_ready", in_ready, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          v;
    logic [DW-1:0] re;
    logic [DW-1:0] im;
    logic          last;
    logic          ordy;
    logic          e_rdy;
    logic          e_ov;
    logic          e_err;
    logic          e_frame;
  } vec_t;

  vec_t          tbl[11];
  int            ev[NN];
  logic [FW-1:0] exp_re, exp_im;

  task automatic check_vec(input int i);
    chk1($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
    chk1($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
    chk1($sformatf("tbl%0d_frame_err", i), frame_err, tbl[i].e_err);
    if (tbl[i].e_frame) begin
      chkf($sformatf("tbl%0d_out_re", i), out_re, exp_re);
      chkf($sformatf("tbl%0d_out_im", i), out_im, exp_im);
    end
  endtask

  initial begin
    int base_out;

    // Natural-order ramp re=k, im=-k; element j of the output holds sample bitrev(j)
    ev = '{0, 4, 2, 6, 1, 5, 3, 7};
    for (int j = 0; j < NN; j++) begin
      exp_re[j*DW +: DW] = DW'(ev[j]);
      exp_im[j*DW +: DW] = DW'(-ev[j]);
    end
    for (int k = 0; k < NN; k++)
      tbl[k] = '{1'b1, DW'(k), DW'(-k), k == 7, 1'b0, 1'b1, k == 7, 1'b0, k == 7};
    tbl[8]  = '{1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, DW'(9), DW'(9), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    do_reset();
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i > 0) check_vec(i - 1);
      in_valid  = tbl[i].v;
      in_re     = tbl[i].re;
      in_im     = tbl[i].im;
      in_last   = tbl[i].last;
      out_ready = tbl[i].ordy;
    end
    @(negedge clk);
    check_vec(10);
    in_valid = 1'b0;

    // Two frames with the consumer stalled, then drained one at a time
    do_reset();
    send_frame(1'b0);
    send_frame(1'b0);
    repeat (4) idle(1'b0);
    idle(1'b1);
    repeat (3) idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Early in_last discards the partial frame; next frame is intact
    for (int k = 0; k < 5; k++)
      step(1'b1, DW'($urandom), DW'($urandom), k == 4, 1'b0);
    repeat (3) idle(1'b0);
    send_frame(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Missing in_last on the 8th sample still commits the frame
    for (int k = 0; k < NN; k++)
      step(1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Continuous stream of 64 samples with the consumer always ready
    base_out = n_dut_out;
    n_stall  = 0;
    for (int k = 0; k < 64; k++)
      step(1'b1, DW'($urandom), DW'($urandom), (k % 8) == 7, 1'b1);
    idle(1'b1);
    idle(1'b1);
    chki("stream_frames_out", n_dut_out - base_out, 8);
    chki("stream_in_ready_stalls", n_stall, 0);

    // Reset mid-frame, then a clean frame
    for (int k = 0; k < 5; k++)
      step(1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
    do_reset();
    send_frame(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Reset with both banks full discards both
    send_frame(1'b0);
    send_frame(1'b0);
    do_reset();
    idle(1'b0);

    // Frame B completes in the same cycle frame A is consumed
    send_frame(1'b0);
    for (int k = 0; k < NN - 1; k++)
      step(1'b1, DW'($urandom), DW'($urandom), 1'b0, 1'b0);
    base_out = n_dut_out;
    step(1'b1, DW'($urandom), DW'($urandom), 1'b1, 1'b1);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    chki("overlap_frames_out", n_dut_out - base_out, 2);

    // Randomized traffic with occasional framing violations
    for (int c = 0; c < 800; c++) begin
      logic v, ordy, last;
      v    = ($urandom % 4) != 0;
      ordy = ($urandom % 3) != 0;
      last = (mcnt == NN - 1) ^ (($urandom % 20) == 0);
      step(v, DW'($urandom), DW'($urandom), last, ordy);
    end
    repeat (4) idle(1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
